// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared encodings for the inst/data sram port arbiter.
package sram_port_arbiter_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;
    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} grant_t;
endpackage

// File: rtl/sram_port_arbiter_tag_fifo.sv
// sram_port_arbiter_tag_fifo: 1-bit owner-tag FIFO tracking outstanding bus transactions.
module sram_port_arbiter_tag_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        din,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic        head,
    output logic [AW:0] count
);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rp];
    assign do_pop = pop & ~empty;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram-like port between inst and data requesters, routing responses by owner tag.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic [AW:0]         outstanding,
    output logic                proto_err
);
    grant_t state, state_nxt;
    logic sel_d, full, empty, head, pop, blocked, accept;
    assign pop = bus_data_ok & ~empty;
    assign blocked = full & ~pop;
    assign sel_d = (state == HOLD_D) | ((state == IDLE) & data_req);
    assign bus_req = resetn & (sel_d ? data_req : inst_req) & ~blocked;
    assign bus_wr = sel_d ? data_wr : inst_wr;
    assign bus_size = sel_d ? data_size : inst_size;
    assign bus_addr = sel_d ? data_addr : inst_addr;
    assign bus_wstrb = sel_d ? data_wstrb : inst_wstrb;
    assign bus_wdata = sel_d ? data_wdata : inst_wdata;
    assign accept = bus_req & bus_addr_ok;
    assign inst_addr_ok = accept & ~sel_d;
    assign data_addr_ok = accept & sel_d;
    assign inst_data_ok = pop & (head == OWN_INST);
    assign data_data_ok = pop & (head == OWN_DATA);
    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;
    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = IDLE;
        else if (bus_req && state == IDLE) state_nxt = sel_d ? HOLD_D : HOLD_I;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus_data_ok && empty) proto_err <= 1'b1;
        end
    end
    sram_port_arbiter_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (accept),
        .din   (sel_d ? OWN_DATA : OWN_INST),
        .pop   (bus_data_ok),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (outstanding)
    );
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 0, resetn = 0;
    logic inst_req, inst_wr, data_req, data_wr;
    logic [1:0] inst_size, data_size, bus_size;
    logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata, bus_addr, bus_wdata, bus_rdata, inst_rdata, data_rdata;
    logic [3:0] inst_wstrb, data_wstrb, bus_wstrb;
    logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic bus_req, bus_wr, bus_addr_ok, bus_data_ok, proto_err;
    logic [2:0] outstanding;
    int n_cmp = 0, n_fail = 0;
    always #5 clk = ~clk;
    sram_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_inputs;
        inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = SZ_WORD; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask
    task automatic do_reset;
        clear_inputs();
        resetn = 0;
        tick();
        resetn = 1;
    endtask
    task automatic test_reset;
        do_reset();
        #1;
        n_cmp++; if ({bus_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin n_fail++; $display("FAIL reset_req got %b want 000", {bus_req, inst_addr_ok, data_addr_ok}); end
        n_cmp++; if ({inst_data_ok, data_data_ok, proto_err} !== 3'b000) begin n_fail++; $display("FAIL reset_ok got %b want 000", {inst_data_ok, data_data_ok, proto_err}); end
        n_cmp++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    endtask
    task automatic test_single_read;
        do_reset();
        data_req = 1; data_addr = 32'h1C00_0010; bus_addr_ok = 1;
        #1;
        n_cmp++; if ({bus_req, data_addr_ok, inst_addr_ok} !== 3'b110) begin n_fail++; $display("FAIL single_issue got %b want 110", {bus_req, data_addr_ok, inst_addr_ok}); end
        n_cmp++; if (bus_addr !== 32'h1C00_0010) begin n_fail++; $display("FAIL single_addr got %h want 1c000010", bus_addr); end
        tick();
        data_req = 0; bus_addr_ok = 0;
        #1;
        n_cmp++; if (outstanding !== 3'd1 || data_data_ok !== 0) begin n_fail++; $display("FAIL single_wait got %0d/%b want 1/0", outstanding, data_data_ok); end
        tick();
        bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin n_fail++; $display("FAIL single_resp got %b want 10", {data_data_ok, inst_data_ok}); end
        n_cmp++; if (data_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata got %h want deadbeef", data_rdata); end
        tick();
        bus_data_ok = 0;
        #1;
        n_cmp++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_drain got %0d want 0", outstanding); end
    endtask
    task automatic test_contention;
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000; bus_addr_ok = 1;
        #1;
        n_cmp++; if ({data_addr_ok, inst_addr_ok} !== 2'b10 || bus_addr !== 32'h2000) begin n_fail++; $display("FAIL cont_first got %b %h want 10 2000", {data_addr_ok, inst_addr_ok}, bus_addr); end
        tick();
        data_req = 0;
        #1;
        n_cmp++; if ({data_addr_ok, inst_addr_ok} !== 2'b01 || bus_addr !== 32'h1000) begin n_fail++; $display("FAIL cont_second got %b %h want 01 1000", {data_addr_ok, inst_addr_ok}, bus_addr); end
        tick();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hAAAA_0001;
        #1;
        n_cmp++; if ({data_data_ok, inst_data_ok} !== 2'b10 || outstanding !== 3'd2) begin n_fail++; $display("FAIL cont_resp_d got %b %0d want 10 2", {data_data_ok, inst_data_ok}, outstanding); end
        tick();
        bus_rdata = 32'hBBBB_0002;
        #1;
        n_cmp++; if ({data_data_ok, inst_data_ok} !== 2'b01 || inst_rdata !== 32'hBBBB_0002) begin n_fail++; $display("FAIL cont_resp_i got %b %h want 01 bbbb0002", {data_data_ok, inst_data_ok}, inst_rdata); end
        tick();
        bus_data_ok = 0;
        #1;
        n_cmp++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL cont_drain got %0d want 0", outstanding); end
    endtask
    task automatic test_hold;
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_3000; data_addr = 32'h0000_4000;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) data_req = 1;
            if (c == 3) bus_addr_ok = 1;
            #1;
            n_cmp++; if (bus_addr !== 32'h3000 || bus_req !== 1) begin n_fail++; $display("FAIL hold_addr c%0d got %h/%b want 3000/1", c, bus_addr, bus_req); end
            n_cmp++; if ({inst_addr_ok, data_addr_ok} !== {c == 3, 1'b0}) begin n_fail++; $display("FAIL hold_ok c%0d got %b want %b0", c, {inst_addr_ok, data_addr_ok}, c == 3); end
            tick();
        end
        inst_req = 0;
        #1;
        n_cmp++; if (data_addr_ok !== 1 || bus_addr !== 32'h4000) begin n_fail++; $display("FAIL hold_data got %b %h want 1 4000", data_addr_ok, bus_addr); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL hold_outstanding got %0d want 2", outstanding); end
    endtask
    task automatic test_full;
        do_reset();
        inst_req = 1; bus_addr_ok = 1;
        for (int k = 0; k < DEPTH; k++) begin
            inst_addr = 32'h100 + 32'(4 * k);
            tick();
        end
        inst_req = 0; data_req = 1; data_addr = 32'h0000_5000;
        #1;
        n_cmp++; if (outstanding !== 3'd4 || bus_req !== 0 || data_addr_ok !== 0) begin n_fail++; $display("FAIL full_block got %0d %b %b want 4 0 0", outstanding, bus_req, data_addr_ok); end
        bus_data_ok = 1;
        #1;
        n_cmp++; if ({bus_req, data_addr_ok, inst_data_ok} !== 3'b111) begin n_fail++; $display("FAIL full_pass got %b want 111", {bus_req, data_addr_ok, inst_data_ok}); end
        tick();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
        #1;
        n_cmp++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", outstanding); end
        for (int k = 0; k < DEPTH; k++) begin
            bus_data_ok = 1;
            #1;
            n_cmp++; if ({inst_data_ok, data_data_ok} !== {k < 3, k == 3}) begin n_fail++; $display("FAIL full_drain%0d got %b want %b%b", k, {inst_data_ok, data_data_ok}, k < 3, k == 3); end
            tick();
        end
        bus_data_ok = 0;
        #1;
        n_cmp++; if (outstanding !== 3'd0 || proto_err !== 0) begin n_fail++; $display("FAIL full_empty got %0d %b want 0 0", outstanding, proto_err); end
    endtask
    task automatic test_spurious;
        do_reset();
        bus_data_ok = 1;
        #1;
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL spur_ok got %b want 00", {inst_data_ok, data_data_ok}); end
        tick();
        bus_data_ok = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (proto_err !== 1) begin n_fail++; $display("FAIL spur_sticky c%0d got %b want 1", c, proto_err); end
            tick();
        end
        do_reset();
        #1;
        n_cmp++; if (proto_err !== 0) begin n_fail++; $display("FAIL spur_clear got %b want 0", proto_err); end
    endtask
    task automatic test_reset_midflight;
        do_reset();
        inst_req = 1; bus_addr_ok = 1; inst_addr = 32'h600;
        tick();
        inst_addr = 32'h604;
        tick();
        bus_addr_ok = 0; inst_addr = 32'h608;
        tick();
        #1;
        n_cmp++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL mid_pre got %0d want 2", outstanding); end
        resetn = 0;
        #1;
        n_cmp++; if (bus_req !== 0 || inst_addr_ok !== 0) begin n_fail++; $display("FAIL mid_during got %b%b want 00", bus_req, inst_addr_ok); end
        tick();
        resetn = 1; data_req = 1; data_addr = 32'h700;
        #1;
        n_cmp++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", outstanding); end
        n_cmp++; if (bus_addr !== 32'h700 || bus_req !== 1) begin n_fail++; $display("FAIL mid_idle got %h %b want 700 1", bus_addr, bus_req); end
        clear_inputs();
    endtask
    task automatic test_random;
        bit q[$];
        int lock;
        bit ip, dp, full_m, pop_m, blocked, sel_d, exp_req, exp_iaok, exp_daok, exp_idok, exp_ddok, accept;
        logic [70:0] exp_bus;
        do_reset();
        lock = -1; ip = 0; dp = 0;
        for (int c = 0; c < 500; c++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1; inst_addr = $urandom; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
                inst_wstrb = 4'($urandom); inst_wdata = $urandom;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; data_addr = $urandom; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            inst_req = ip; data_req = dp;
            bus_addr_ok = $urandom_range(0, 2) != 0;
            bus_data_ok = q.size() > 0 && $urandom_range(0, 2) == 0;
            bus_rdata = $urandom;
            #1;
            full_m = q.size() == DEPTH;
            pop_m = bus_data_ok && q.size() > 0;
            blocked = full_m && !pop_m;
            sel_d = lock == 1 ? 1 : lock == 0 ? 0 : dp;
            exp_req = (sel_d ? dp : ip) && !blocked;
            accept = exp_req && bus_addr_ok;
            exp_iaok = accept && !sel_d;
            exp_daok = accept && sel_d;
            exp_idok = pop_m && q[0] == OWN_INST;
            exp_ddok = pop_m && q[0] == OWN_DATA;
            exp_bus = sel_d ? {data_wr, data_size, data_addr, data_wstrb, data_wdata} : {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
            n_cmp++; if (bus_req !== exp_req) begin n_fail++; $display("FAIL rnd_bus_req c%0d got %b want %b", c, bus_req, exp_req); end
            if (exp_req) begin
                n_cmp++; if ({bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata} !== exp_bus) begin n_fail++; $display("FAIL rnd_bus_fields c%0d got %h want %h", c, {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata}, exp_bus); end
            end
            n_cmp++; if ({inst_addr_ok, data_addr_ok} !== {exp_iaok, exp_daok}) begin n_fail++; $display("FAIL rnd_addr_ok c%0d got %b want %b%b", c, {inst_addr_ok, data_addr_ok}, exp_iaok, exp_daok); end
            n_cmp++; if ({inst_data_ok, data_data_ok} !== {exp_idok, exp_ddok}) begin n_fail++; $display("FAIL rnd_data_ok c%0d got %b want %b%b", c, {inst_data_ok, data_data_ok}, exp_idok, exp_ddok); end
            n_cmp++; if (outstanding !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_outstanding c%0d got %0d want %0d", c, outstanding, q.size()); end
            n_cmp++; if (inst_rdata !== bus_rdata || data_rdata !== bus_rdata || proto_err !== 0) begin n_fail++; $display("FAIL rnd_rdata_err c%0d got %h %h %b want %h 0", c, inst_rdata, data_rdata, proto_err, bus_rdata); end
            if (pop_m) void'(q.pop_front());
            if (accept) q.push_back(sel_d);
            if (accept) lock = -1;
            else if (exp_req) lock = sel_d ? 1 : 0;
            if (exp_iaok) ip = 0;
            if (exp_daok) dp = 0;
            tick();
        end
        clear_inputs();
    endtask
    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_hold();
        test_full();
        test_spurious();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
